mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arb_pkg.sv | 21 ++
 rtl/mem_arb_grant.sv | 22 ++
 rtl/mem_arbiter.sv | 114 +++++++++++
 tb/tb_mem_arbiter.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg -- shared types and default widths for the memory arbiter.
//   rsp_owner_e : which requester owns the response returning next cycle
//   win_e       : which port won the most recent conflicting request
//   DEF_*       : default memory word / word-address widths
package mem_arb_pkg;

   localparam int DEF_M_WIDTH    = 32;
   localparam int DEF_ADDR_WIDTH = 30;

   typedef enum logic [1:0] {
      RSP_NONE = 2'd0,
      RSP_IF   = 2'd1,
      RSP_LS   = 2'd2
   } rsp_owner_e;

   typedef enum logic {
      WIN_IF = 1'b0,
      WIN_LS = 1'b1
   } win_e;

endpackage

// File: rtl/mem_arb_grant.sv
// mem_arb_grant -- combinational two-port grant logic.
//   if_valid / ls_valid : qualified request valids (already masked by reset)
//   last_win            : port that won the previous conflict
//   if_grant / ls_grant : one-hot (or zero) grants
// On a conflict the port that did not win last time is served. Holding
// last_win at WIN_IF makes load/store win every conflict (fixed priority).
module mem_arb_grant
   import mem_arb_pkg::*;
(
   input  logic if_valid,
   input  logic ls_valid,
   input  win_e last_win,
   output logic if_grant,
   output logic ls_grant
);

   always_comb begin
      ls_grant = ls_valid & (~if_valid | (last_win == WIN_IF));
      if_grant = if_valid & ~ls_grant;
   end

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter -- shares one single-port synchronous memory between an
// instruction-fetch port (read only) and a load/store port.
//   clk, rst              : clock, synchronous active-high reset
//   if_req_* / if_rsp_*   : fetch request (valid/addr/ready), response (valid/data)
//   ls_req_* / ls_rsp_*   : load/store request (valid/addr/wdata/wes/ready),
//                           response (valid/data); wes == 0 means load
//   mem_addr/wdata/wes    : memory request driven in the grant cycle
//   mem_rdata             : memory read data, one cycle after the request
// Build option: define MEM_ARB_RR_EN for round-robin conflict resolution;
// otherwise load/store always beats fetch.
module mem_arbiter
   import mem_arb_pkg::*;
#(
   parameter int M_WIDTH    = DEF_M_WIDTH,
   parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
   parameter int WE_WIDTH   = M_WIDTH / 8
)(
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  if_req_valid,
   input  logic [ADDR_WIDTH-1:0] if_req_addr,
   output logic                  if_req_ready,
   output logic                  if_rsp_valid,
   output logic [M_WIDTH-1:0]    if_rsp_data,
   input  logic                  ls_req_valid,
   input  logic [ADDR_WIDTH-1:0] ls_req_addr,
   input  logic [M_WIDTH-1:0]    ls_req_wdata,
   input  logic [WE_WIDTH-1:0]   ls_req_wes,
   output logic                  ls_req_ready,
   output logic                  ls_rsp_valid,
   output logic [M_WIDTH-1:0]    ls_rsp_data,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   output logic [M_WIDTH-1:0]    mem_wdata,
   output logic [WE_WIDTH-1:0]   mem_wes,
   input  logic [M_WIDTH-1:0]    mem_rdata
);

   logic                  if_valid_q;
   logic                  ls_valid_q;
   logic                  grant_if;
   logic                  grant_ls;
   win_e                  last_win;
   rsp_owner_e            rsp_owner_p1;
   logic [ADDR_WIDTH-1:0] last_addr_p1;

   // Reset masks requests so nothing is granted (and no write issued) in rst.
   assign if_valid_q = if_req_valid & ~rst;
   assign ls_valid_q = ls_req_valid & ~rst;

`ifdef MEM_ARB_RR_EN
   // Only conflicts move the last-winner flop; solo grants leave it alone.
   always_ff @(posedge clk) begin
      if (rst)
         last_win <= WIN_IF;
      else if (if_valid_q && ls_valid_q)
         last_win <= grant_ls ? WIN_LS : WIN_IF;
   end
`else
   assign last_win = WIN_IF;
`endif

   mem_arb_grant u_grant (
      .if_valid (if_valid_q),
      .ls_valid (ls_valid_q),
      .last_win (last_win),
      .if_grant (grant_if),
      .ls_grant (grant_ls)
   );

   assign if_req_ready = grant_if;
   assign ls_req_ready = grant_ls;

   // Stage 0 -> 1: remember who owns next cycle's read data and the last
   // granted address (memory keeps seeing it while idle).
   always_ff @(posedge clk) begin
      if (rst) begin
         rsp_owner_p1 <= RSP_NONE;
         last_addr_p1 <= '0;
      end else begin
         if (grant_ls) begin
            rsp_owner_p1 <= RSP_LS;
            last_addr_p1 <= ls_req_addr;
         end else if (grant_if) begin
            rsp_owner_p1 <= RSP_IF;
            last_addr_p1 <= if_req_addr;
         end else begin
            rsp_owner_p1 <= RSP_NONE;
         end
      end
   end

   always_comb begin
      mem_addr  = last_addr_p1;
      mem_wdata = '0;
      mem_wes   = '0;
      if (rst) begin
         mem_addr = '0;
      end else if (grant_ls) begin
         mem_addr  = ls_req_addr;
         mem_wdata = ls_req_wdata;
         mem_wes   = ls_req_wes;
      end else if (grant_if) begin
         mem_addr = if_req_addr;
      end
   end

   // Responses are suppressed while rst is high, even for a grant issued
   // in the cycle just before reset.
   assign if_rsp_valid = ~rst & (rsp_owner_p1 == RSP_IF);
   assign ls_rsp_valid = ~rst & (rsp_owner_p1 == RSP_LS);
   assign if_rsp_data  = mem_rdata;
   assign ls_rsp_data  = mem_rdata;

endmodule

// File: tb/tb_mem_arbiter.sv
module tb_mem_arbiter;

   localparam int MW = 32;
   localparam int AW = 30;
   localparam int WW = 4;

   logic          clk = 1'b0;
   logic          rst;
   logic          if_req_valid;
   logic [AW-1:0] if_req_addr;
   logic          if_req_ready;
   logic          if_rsp_valid;
   logic [MW-1:0] if_rsp_data;
   logic          ls_req_valid;
   logic [AW-1:0] ls_req_addr;
   logic [MW-1:0] ls_req_wdata;
   logic [WW-1:0] ls_req_wes;
   logic          ls_req_ready;
   logic          ls_rsp_valid;
   logic [MW-1:0] ls_rsp_data;
   logic [AW-1:0] mem_addr;
   logic [MW-1:0] mem_wdata;
   logic [WW-1:0] mem_wes;
   logic [MW-1:0] mem_rdata = '0;

   always #5 clk = ~clk;

   mem_arbiter dut (
      .clk          (clk),
      .rst          (rst),
      .if_req_valid (if_req_valid),
      .if_req_addr  (if_req_addr),
      .if_req_ready (if_req_ready),
      .if_rsp_valid (if_rsp_valid),
      .if_rsp_data  (if_rsp_data),
      .ls_req_valid (ls_req_valid),
      .ls_req_addr  (ls_req_addr),
      .ls_req_wdata (ls_req_wdata),
      .ls_req_wes   (ls_req_wes),
      .ls_req_ready (ls_req_ready),
      .ls_rsp_valid (ls_rsp_valid),
      .ls_rsp_data  (ls_rsp_data),
      .mem_addr     (mem_addr),
      .mem_wdata    (mem_wdata),
      .mem_wes      (mem_wes),
      .mem_rdata    (mem_rdata)
   );

   // Memory attached to the DUT: registered read of the pre-write word.
   logic [MW-1:0] tb_mem [64];
   always @(posedge clk) begin
      mem_rdata <= tb_mem[mem_addr[5:0]];
      for (int b = 0; b < WW; b++)
         if (mem_wes[b]) tb_mem[mem_addr[5:0]][b*8 +: 8] <= mem_wdata[b*8 +: 8];
   end

   // Reference model state.
   logic [MW-1:0] ref_mem [64];
   int            pend_owner;   // 0 none, 1 fetch, 2 load/store
   logic [MW-1:0] pend_data;
   bit            pend_read;
   bit            last_ls;      // last conflict went to load/store
   logic [AW-1:0] last_addr;
   bit            mg_if, mg_ls;

   int total = 0;
   int bad   = 0;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic model_check();
      bit            gi, gl;
      logic [AW-1:0] ea;
      logic [5:0]    idx;
      chk("if_rsp_valid", if_rsp_valid, (!rst && pend_owner == 1));
      chk("ls_rsp_valid", ls_rsp_valid, (!rst && pend_owner == 2));
      if (!rst && pend_owner == 1) chk("if_rsp_data", if_rsp_data, pend_data);
      if (!rst && pend_owner == 2 && pend_read) chk("ls_rsp_data", ls_rsp_data, pend_data);

      gi = 0; gl = 0;
      if (rst) begin
         last_ls = 0;
      end else if (if_req_valid && ls_req_valid) begin
`ifdef MEM_ARB_RR_EN
         gl = !last_ls;
`else
         gl = 1;
`endif
         gi = !gl;
         last_ls = gl;
      end else begin
         gi = if_req_valid;
         gl = ls_req_valid;
      end
      chk("if_req_ready", if_req_ready, gi);
      chk("ls_req_ready", ls_req_ready, gl);
      ea = rst ? '0 : gl ? ls_req_addr : gi ? if_req_addr : last_addr;
      chk("mem_addr", mem_addr, ea);
      chk("mem_wes", mem_wes, gl ? ls_req_wes : 4'h0);
      if (gl) chk("mem_wdata", mem_wdata, ls_req_wdata);

      idx        = gl ? ls_req_addr[5:0] : if_req_addr[5:0];
      pend_owner = rst ? 0 : gl ? 2 : gi ? 1 : 0;
      pend_data  = ref_mem[idx];
      pend_read  = gi || (gl && ls_req_wes == 0);
      if (gl)
         for (int b = 0; b < WW; b++)
            if (ls_req_wes[b]) ref_mem[idx][b*8 +: 8] = ls_req_wdata[b*8 +: 8];
      last_addr = ea;
      mg_if = gi;
      mg_ls = gl;
   endtask

   task automatic step(input logic r, input logic iv, input logic [AW-1:0] ia,
                       input logic lv, input logic [AW-1:0] la,
                       input logic [MW-1:0] wd, input logic [WW-1:0] we);
      @(posedge clk);
      #1;
      rst = r; if_req_valid = iv; if_req_addr = ia;
      ls_req_valid = lv; ls_req_addr = la; ls_req_wdata = wd; ls_req_wes = we;
      @(negedge clk);
      model_check();
   endtask

   initial begin
      bit exp_ls [4];
      logic          iv, lv, r;
      logic [AW-1:0] ia, la;
      logic [MW-1:0] wd;
      logic [WW-1:0] we;

      for (int i = 0; i < 64; i++) begin
         tb_mem[i]  = (32'h0101_0101 * i) ^ 32'hA500_0000;
         ref_mem[i] = (32'h0101_0101 * i) ^ 32'hA500_0000;
      end
      tb_mem[16] = 32'h0000_0513; ref_mem[16] = 32'h0000_0513;
      tb_mem[56] = 32'h0;         ref_mem[56] = 32'h0;
      pend_owner = 0; pend_data = '0; pend_read = 0; last_ls = 0;
      last_addr = '0; mg_if = 0; mg_ls = 0;
      rst = 1; if_req_valid = 0; if_req_addr = '0; ls_req_valid = 0;
      ls_req_addr = '0; ls_req_wdata = '0; ls_req_wes = '0;

      // Reset with requests pending: nothing granted, no write.
      step(1, 1, 30'h5, 1, 30'h6, 32'hFFFF_FFFF, 4'hF);
      step(1, 1, 30'h5, 1, 30'h6, 32'hFFFF_FFFF, 4'hF);
      chk("rst_if_ready", if_req_ready, 1'b0);
      chk("rst_ls_ready", ls_req_ready, 1'b0);
      chk("rst_mem_wes", mem_wes, 4'h0);
      chk("rst_mem_addr", mem_addr, 30'h0);

      // Conflict for 4 cycles straight out of reset.
`ifdef MEM_ARB_RR_EN
      exp_ls = '{1, 0, 1, 0};
`else
      exp_ls = '{1, 1, 1, 1};
`endif
      for (int i = 0; i < 4; i++) begin
         step(0, 1, 30'h10, 1, 30'h20, 32'h0, 4'h0);
         chk("conflict_ls_ready", ls_req_ready, exp_ls[i]);
         chk("conflict_if_ready", if_req_ready, !exp_ls[i]);
      end

      // Fetch only.
      step(0, 1, 30'h10, 0, 30'h0, 32'h0, 4'h0);
      chk("fetch_ready", if_req_ready, 1'b1);
      step(0, 0, 30'h0, 0, 30'h0, 32'h0, 4'h0);
      chk("fetch_rsp_valid", if_rsp_valid, 1'b1);
      chk("fetch_rsp_data", if_rsp_data, 32'h0000_0513);

      // Store then load to 0x38, then idle.
      step(0, 0, 30'h0, 1, 30'h38, 32'h0000_000D, 4'b0001);
      chk("store_mem_wes", mem_wes, 4'b0001);
      step(0, 0, 30'h0, 1, 30'h38, 32'h0, 4'h0);
      chk("store_ack", ls_rsp_valid, 1'b1);
      for (int i = 0; i < 3; i++) begin
         step(0, 0, 30'h0, 0, 30'h0, 32'h0, 4'h0);
         if (i == 0) chk("load_data", ls_rsp_data, 32'h0000_000D);
         else        chk("idle_no_rsp", {if_rsp_valid, ls_rsp_valid}, 2'b00);
         chk("idle_mem_addr", mem_addr, 30'h38);
         chk("idle_mem_wes", mem_wes, 4'h0);
      end

      // Reset mid-access.
      step(0, 1, 30'h10, 0, 30'h0, 32'h0, 4'h0);
      step(1, 0, 30'h0, 1, 30'h38, 32'hFF, 4'hF);
      chk("rst_mid_if_rsp", if_rsp_valid, 1'b0);
      chk("rst_mid_wes", mem_wes, 4'h0);
      step(0, 0, 30'h0, 0, 30'h0, 32'h0, 4'h0);
      chk("rst_after_if_rsp", if_rsp_valid, 1'b0);

      // Random traffic; requests stay stable until granted.
      for (int n = 0; n < 400; n++) begin
         r = ($urandom_range(0, 39) == 0);
         if (if_req_valid && !mg_if) begin
            iv = 1; ia = if_req_addr;
         end else begin
            iv = $urandom_range(0, 1); ia = AW'($urandom_range(0, 63));
         end
         if (ls_req_valid && !mg_ls) begin
            lv = 1; la = ls_req_addr; wd = ls_req_wdata; we = ls_req_wes;
         end else begin
            lv = $urandom_range(0, 1); la = AW'($urandom_range(0, 63));
            wd = $urandom;
            we = $urandom_range(0, 1) ? 4'h0 : WW'($urandom_range(0, 15));
         end
         step(r, iv, ia, lv, la, wd, we);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
